// File: rtl/q100_tcm_router.sv
// Memory router for the q100 EXU load/store port. Decodes each request to the internal TCM
// (fixed 1-cycle response) or to an external req/ack bus with an optional timeout.
module q100_tcm_router #(
  parameter int DATA_WIDTH    = 32,
  parameter int BANK          = 4,
  parameter int ADDR_WIDTH    = 16,
  parameter int INT_ADDR_BITS = 12,
  parameter int INT_BASE      = 0,
  parameter int EXT_EN        = 1,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [BANK-1:0]          req_we_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [INT_ADDR_BITS-1:0] int_addr_o,
  output logic [BANK-1:0]          int_we_o,
  output logic [DATA_WIDTH-1:0]    int_wdata_o,
  input  logic [DATA_WIDTH-1:0]    int_rdata_i,
  output logic                     ext_req_o,
  output logic [ADDR_WIDTH-1:0]    ext_addr_o,
  output logic [BANK-1:0]          ext_we_o,
  output logic [DATA_WIDTH-1:0]    ext_wdata_o,
  input  logic                     ext_ack_i,
  input  logic [DATA_WIDTH-1:0]    ext_rdata_i,
  input  logic                     ext_err_i,
  output logic                     busy_o
);

  localparam int TAG_W = ADDR_WIDTH - INT_ADDR_BITS;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TAG_W-1:0] INT_TAG  = TAG_W'(INT_BASE);

  typedef enum logic {
    S_IDLE,
    S_EXT_WAIT
  } state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_int_rd;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_ext_req;
  logic [ADDR_WIDTH-1:0]   r_ext_addr;
  logic [BANK-1:0]         r_ext_we;
  logic [DATA_WIDTH-1:0]   r_ext_wdata;
  logic [CNT_W-1:0]        r_cnt;

  logic w_accept;
  logic w_is_int;
  logic w_timeout;
  logic w_ext_done;

  // r_ready is only ever high in S_IDLE, so an accept implies the FSM is idle.
  assign w_accept   = req_valid_i & r_ready;
  assign w_is_int   = (req_addr_i[ADDR_WIDTH-1:INT_ADDR_BITS] == INT_TAG);
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_ext_done = ext_ack_i | w_timeout;

  // NOTE: the TCM port is driven straight from the request so its sync read lands in the next cycle.
  assign int_addr_o  = req_addr_i[INT_ADDR_BITS-1:0];
  assign int_we_o    = (w_accept && w_is_int) ? req_we_i : '0;
  assign int_wdata_o = req_wdata_i;

  assign req_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_int_rd ? int_rdata_i : r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign ext_req_o   = r_ext_req;
  assign ext_addr_o  = r_ext_addr;
  assign ext_we_o    = r_ext_we;
  assign ext_wdata_o = r_ext_wdata;
  assign busy_o      = (r_state != S_IDLE);

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_int_rd <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_ext_req    <= 1'b0;
      r_ext_addr   <= '0;
      r_ext_we     <= '0;
      r_ext_wdata  <= '0;
      r_cnt        <= '0;
    end else begin
      r_rsp_valid  <= 1'b0;
      r_rsp_int_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            if (w_is_int) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_int_rd <= (req_we_i == '0);
              r_rsp_rdata  <= '0;
              r_rsp_err    <= 1'b0;
            end else if (EXT_EN != 0) begin
              r_state     <= S_EXT_WAIT;
              r_ready     <= 1'b0;
              r_ext_req   <= 1'b1;
              r_ext_addr  <= req_addr_i;
              r_ext_we    <= req_we_i;
              r_ext_wdata <= req_wdata_i;
              r_cnt       <= '0;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        S_EXT_WAIT: begin
          if (w_ext_done) begin
            // An ack in the timeout cycle takes priority; any error returns zero data.
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_ext_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ext_ack_i ? ext_err_i : 1'b1;
            r_rsp_rdata <= (ext_ack_i && !ext_err_i && (r_ext_we == '0)) ? ext_rdata_i : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q100_tcm_router.sv
// Bench for q100_tcm_router: directed scenarios plus randomized traffic scored against a
// word-level memory model and a per-request expected response queue.
module tb_q100_tcm_router;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [3:0]  req_we_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, ext_req_o, busy_o;
  logic [31:0] rsp_rdata_o, int_wdata_o, ext_wdata_o;
  logic [11:0] int_addr_o;
  logic [3:0]  int_we_o, ext_we_o;
  logic [15:0] ext_addr_o;
  logic [31:0] int_rdata_i;
  logic        ext_ack_i = 1'b0;
  logic [31:0] ext_rdata_i = '0;
  logic        ext_err_i = 1'b0;

  // Second instance with the external bus disabled.
  logic        n_req_valid_i = 1'b0;
  logic [15:0] n_req_addr_i = '0;
  logic [3:0]  n_req_we_i = '0;
  logic        n_req_ready_o, n_rsp_valid_o, n_rsp_err_o, n_ext_req_o, n_busy_o;
  logic [31:0] n_rsp_rdata_o, n_int_wdata_o, n_ext_wdata_o;
  logic [11:0] n_int_addr_o;
  logic [3:0]  n_int_we_o, n_ext_we_o;
  logic [15:0] n_ext_addr_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit   [31:0] tcm     [4096];
  bit   [31:0] ref_mem [4096];
  logic [31:0] exp_rdata [$];
  logic        exp_err   [$];
  logic [31:0] obs_rdata [$];
  logic        obs_err   [$];
  int          obs_cyc   [$];

  q100_tcm_router #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .int_addr_o(int_addr_o), .int_we_o(int_we_o), .int_wdata_o(int_wdata_o),
    .int_rdata_i(int_rdata_i),
    .ext_req_o(ext_req_o), .ext_addr_o(ext_addr_o), .ext_we_o(ext_we_o),
    .ext_wdata_o(ext_wdata_o), .ext_ack_i(ext_ack_i), .ext_rdata_i(ext_rdata_i),
    .ext_err_i(ext_err_i), .busy_o(busy_o)
  );

  q100_tcm_router #(.EXT_EN(0), .TIMEOUT(TO)) dut_noext (
    .clk(clk), .rst(rst),
    .req_valid_i(n_req_valid_i), .req_ready_o(n_req_ready_o), .req_addr_i(n_req_addr_i),
    .req_we_i(n_req_we_i), .req_wdata_i(32'h0),
    .rsp_valid_o(n_rsp_valid_o), .rsp_rdata_o(n_rsp_rdata_o), .rsp_err_o(n_rsp_err_o),
    .int_addr_o(n_int_addr_o), .int_we_o(n_int_we_o), .int_wdata_o(n_int_wdata_o),
    .int_rdata_i(32'hCAFEF00D),
    .ext_req_o(n_ext_req_o), .ext_addr_o(n_ext_addr_o), .ext_we_o(n_ext_we_o),
    .ext_wdata_o(n_ext_wdata_o), .ext_ack_i(1'b0), .ext_rdata_i(32'h0),
    .ext_err_i(1'b0), .busy_o(n_busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sync-read TCM attached to the internal port.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (int_we_o[b]) tcm[int_addr_o][b*8 +: 8] <= int_wdata_o[b*8 +: 8];
    int_rdata_i <= tcm[int_addr_o];
  end

  always @(negedge clk) begin
    if (rsp_valid_o === 1'b1) begin
      obs_rdata.push_back(rsp_rdata_o);
      obs_err.push_back(rsp_err_o);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (we[b]) m[b*8 +: 8] = d[b*8 +: 8];
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents one request for exactly one accept edge.
  task automatic send(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
    int n;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_req", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_we_i    = we;
    req_wdata_i = d;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic int_req(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [11:0] w;
    w = a[11:0];
    if (we == 4'h0) begin
      exp_rdata.push_back(ref_mem[w]);
    end else begin
      exp_rdata.push_back(32'h0);
      ref_mem[w] = merge(ref_mem[w], we, d);
    end
    exp_err.push_back(1'b0);
    send(a, we, d);
  endtask

  // External access; the slave acks once ext_req_o has been high for `delay` cycles
  // (delay==0 means ack in the first request cycle), unless the router times out first.
  task automatic ext_txn(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d,
                         input int delay, input logic [31:0] ack_data, input logic ack_err,
                         input bit poke);
    int   hi, exp_hi;
    bit   acked;
    logic rdy_seen;
    logic [3:0] we_leak;
    acked  = (delay <= TO - 1);
    exp_hi = acked ? delay + 1 : TO;
    exp_rdata.push_back((acked && !ack_err && we == 4'h0) ? ack_data : 32'h0);
    exp_err.push_back(acked ? ack_err : 1'b1);
    send(a, we, d);
    check("ext_addr", {16'h0, ext_addr_o}, {16'h0, a});
    check("ext_we", {28'h0, ext_we_o}, {28'h0, we});
    check("ext_wdata", ext_wdata_o, d);
    hi = 0;
    rdy_seen = 1'b0;
    we_leak = 4'h0;
    while (ext_req_o === 1'b1 && hi < 200) begin
      rdy_seen = rdy_seen | req_ready_o;
      we_leak  = we_leak | int_we_o;
      if (poke) begin
        req_valid_i = 1'b1;
        req_addr_i  = 16'h0FFF;
        req_we_i    = 4'hF;
        req_wdata_i = 32'h0BAD0BAD;
      end
      ext_ack_i   = (hi == delay);
      ext_rdata_i = ack_data;
      ext_err_i   = ack_err;
      @(negedge clk);
      hi++;
      ext_ack_i = 1'b0;
    end
    req_valid_i = 1'b0;
    check("ext_req_cycles", hi, exp_hi);
    check("rsp_after_ext", {31'b0, rsp_valid_o}, 32'd1);
    check("ready_low_in_wait", {31'b0, rdy_seen}, 32'd0);
    check("ready_after_ext", {31'b0, req_ready_o}, 32'd1);
    if (poke) check("no_accept_in_wait", {28'h0, we_leak}, 32'd0);
  endtask

  task automatic compare_rsps(input string tag);
    int n;
    n = 0;
    while (obs_rdata.size() < exp_rdata.size() && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, obs_rdata.size(), exp_rdata.size());
    while (exp_rdata.size() > 0 && obs_rdata.size() > 0) begin
      check({tag, "_rdata"}, obs_rdata.pop_front(), exp_rdata.pop_front());
      check({tag, "_err"}, {31'b0, obs_err.pop_front()}, {31'b0, exp_err.pop_front()});
    end
    exp_rdata.delete();
    exp_err.delete();
    obs_rdata.delete();
    obs_err.delete();
    obs_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and ready release.
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready_o}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_ext_req", {31'b0, ext_req_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_ext_addr", {16'h0, ext_addr_o}, 32'd0);
    #1 rst = 1'b1;
    #1 check("ready_before_edge", {31'b0, req_ready_o}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'b0, req_ready_o}, 32'd1);
    check("int_we_idle", {28'h0, int_we_o}, 32'd0);

    // 1: four back-to-back writes, four reads, one response per cycle.
    for (int i = 0; i < 4; i++) int_req(16'(i), 4'hF, 32'hA5000000 + 32'(i * 32'h01010101));
    for (int i = 0; i < 4; i++) int_req(16'(i), 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("t1_consecutive", (obs_cyc.size() == 8) ? 32'(obs_cyc[7] - obs_cyc[0]) : 32'hFFFF_FFFF,
          32'd7);
    compare_rsps("t1");

    // 2: partial byte write over a full word.
    int_req(16'h0010, 4'hF, 32'h11223344);
    int_req(16'h0010, 4'b0011, 32'hAABBCCDD);
    int_req(16'h0010, 4'h0, 32'h0);
    compare_rsps("t2");

    // 3: external read acked 5 cycles after ext_req_o rises; held request must not be taken.
    ext_txn(16'h1000, 4'h0, 32'h0, 5, 32'hDEADBEEF, 1'b0, 1'b1);
    compare_rsps("t3");

    // 4: external write with no ack times out, then the next request is accepted.
    ext_txn(16'h4321, 4'hF, 32'h55AA55AA, 100, 32'h0, 1'b0, 1'b0);
    int_req(16'h0010, 4'h0, 32'h0);
    compare_rsps("t4");

    // 5: ack exactly on the last counter value, with and without error; also ack at count 0.
    ext_txn(16'h8000, 4'h0, 32'h0, TO - 1, 32'h12345678, 1'b1, 1'b0);
    ext_txn(16'h8004, 4'h0, 32'h0, TO - 1, 32'h87654321, 1'b0, 1'b0);
    ext_txn(16'hF00F, 4'h0, 32'h0, 0, 32'h0F0F0F0F, 1'b0, 1'b0);
    int_req(16'h0001, 4'h0, 32'h0);
    ext_txn(16'h2222, 4'h0, 32'h0, 2, 32'h33334444, 1'b0, 1'b0);
    compare_rsps("t5");

    // Stray ack while idle produces nothing.
    ext_ack_i = 1'b1;
    ext_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    ext_ack_i = 1'b0;
    @(negedge clk);
    check("stray_ack_busy", {31'b0, busy_o}, 32'd0);
    compare_rsps("stray_ack");

    // 6: reset during EXT_WAIT drops the request.
    send(16'h2000, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("t6_busy", {31'b0, busy_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_ext_req_clear", {31'b0, ext_req_o}, 32'd0);
    check("t6_rsp_clear", {31'b0, rsp_valid_o}, 32'd0);
    check("t6_ready_clear", {31'b0, req_ready_o}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("t6_ready_pre_edge", {31'b0, req_ready_o}, 32'd0);
    @(negedge clk);
    check("t6_ready_post_edge", {31'b0, req_ready_o}, 32'd1);
    compare_rsps("t6");
    for (int i = 0; i < 4096; i++) ref_mem[i] = tcm[i];

    // Randomized mix of internal and external traffic.
    for (int t = 0; t < 150; t++) begin
      int          r;
      logic [15:0] a;
      logic [3:0]  we;
      logic [31:0] d;
      r  = int'($urandom_range(0, 99));
      we = (r % 3 == 0) ? 4'h0 : 4'($urandom);
      d  = $urandom;
      if (r < 75) begin
        a = 16'h0020 + 16'($urandom_range(0, 15));
        int_req(a, we, d);
      end else begin
        a = {4'($urandom_range(1, 15)), 12'($urandom)};
        ext_txn(a, we, d, int'($urandom_range(0, 10)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    compare_rsps("rand");

    // External bus disabled: external address gets a 1-cycle error response.
    n_req_addr_i  = 16'h3456;
    n_req_we_i    = 4'h0;
    n_req_valid_i = 1'b1;
    @(negedge clk);
    n_req_valid_i = 1'b0;
    check("noext_rsp_valid", {31'b0, n_rsp_valid_o}, 32'd1);
    check("noext_rsp_err", {31'b0, n_rsp_err_o}, 32'd1);
    check("noext_rsp_rdata", n_rsp_rdata_o, 32'h0);
    check("noext_ext_req", {31'b0, n_ext_req_o}, 32'd0);
    check("noext_ready", {31'b0, n_req_ready_o}, 32'd1);
    @(negedge clk);
    check("noext_single_rsp", {31'b0, n_rsp_valid_o}, 32'd0);
    check("noext_busy", {31'b0, n_busy_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
